fork_cond2_src_2ph: RTL and testbench

Clocked source stage that feeds a two-channel conditional fork on a 2-phase single-rail channel. It accepts one word plus a 2-bit destination mask per valid/ready transfer from the synchronous domain. It presents the mask as `cond1`/`cond2` and the word as bundled data, then toggles `r`. It waits for the fork's `a` toggle, synchronised into `clk`, before accepting the next transfer.

---
 rtl/fork_cond2_src_pkg.sv | 13 +
 rtl/fork_cond2_src_2ph_sync.sv | 24 ++
 rtl/fork_cond2_src_2ph.sv | 140 ++++++++++++++
 tb/tb_fork_cond2_src_2ph.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fork_cond2_src_pkg.sv
// Shared types and default constants for the 2-phase conditional-fork source stage.
package fork_cond2_src_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/fork_cond2_src_2ph_sync.sv
// N-flop synchroniser bringing the asynchronous 2-phase ack into the clk domain.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // shift the async input through the flop chain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chain_r <= '0;
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/fork_cond2_src_2ph.sv
// Clocked source feeding a two-channel conditional fork over a 2-phase bundled-data channel.
// Optional ack watchdog enabled by defining FORK_COND2_SRC_TIMEOUT_EN.
module fork_cond2_src_2ph
   import fork_cond2_src_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_cond,
   output logic [WIDTH-1:0] data,
   output logic             cond1,
   output logic             cond2,
   output logic             r,
   input  logic             a,
   output logic             busy,
   output logic             err
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic             a_s;
   logic             r_r;
   logic [WIDTH-1:0] data_r;
   logic [1:0]       cond_r;
   logic             err_r;
   logic             accept_s;
   logic             spurious_s;
   logic             timeout_s;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (a),
      .q    (a_s)
   );

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state decode: accept in IDLE, one margin cycle, then wait for a_s to match r
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nxt_s = SETUP;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SETUP: begin
            state_nxt_s = WAIT;
         end
         WAIT: begin
            if (a_s == r_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // outside WAIT the fork must be quiescent, so any phase difference is a protocol error
   assign spurious_s = (state_r != WAIT) && (a_s != r_r);

`ifdef FORK_COND2_SRC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wd_cnt_r;

   // watchdog: cleared while entering WAIT, saturates at TIMEOUT_CYCLES-1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_cnt_r <= '0;
      end else if (state_r == SETUP) begin
         wd_cnt_r <= '0;
      end else if ((state_r == WAIT) && (wd_cnt_r != CNT_W'(TIMEOUT_CYCLES - 1))) begin
         wd_cnt_r <= wd_cnt_r + CNT_W'(1);
      end
   end

   // flags on the edge where the count reaches TIMEOUT_CYCLES-1; FSM keeps waiting
   assign timeout_s = (state_r == WAIT) && (a_s != r_r) &&
                      (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 2));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign timeout_s = 1'b0;
`endif

   // bundled data, request phase and sticky error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_r <= '0;
         cond_r <= 2'b00;
         r_r    <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            data_r <= in_data;
            cond_r <= in_cond;
         end
         if (state_r == SETUP) begin
            r_r <= ~r_r;
         end
         if (spurious_s || timeout_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign in_ready = (state_r == IDLE);
   assign busy     = (state_r == WAIT);
   assign r        = r_r;
   assign data     = data_r;
   assign cond1    = cond_r[0];
   assign cond2    = cond_r[1];
   assign err      = err_r;

endmodule

// File: tb/tb_fork_cond2_src_2ph.sv
// Self-checking bench for fork_cond2_src_2ph with a behavioural fork/ack model.
module tb_fork_cond2_src_2ph;

   localparam int W    = 8;
   localparam int SYNC = 2;
   localparam int TO   = 16;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [1:0]   in_cond = 2'b00;
   logic         a = 1'b0;
   logic         in_ready;
   logic [W-1:0] data;
   logic         cond1;
   logic         cond2;
   logic         r;
   logic         busy;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_r   = 1'b0;
   logic exp_err = 1'b0;

   fork_cond2_src_2ph #(
      .WIDTH          (W),
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_cond  (in_cond),
      .data     (data),
      .cond1    (cond1),
      .cond2    (cond2),
      .r        (r),
      .a        (a),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   // One token: present at a negedge with DUT idle; the fork acks 'delay' cycles after r toggles.
   task automatic do_transfer(input logic [W-1:0] word, input logic [1:0] mask, input int delay,
                              input bit hold, input logic [W-1:0] nword, input logic [1:0] nmask);
      int k;
      in_valid = 1'b1;
      in_data  = word;
      in_cond  = mask;
      @(negedge clk);
      n_checks++;
      if ({data, cond2, cond1, in_ready, r} !== {word, mask, 1'b0, exp_r}) begin
         n_fail++;
         $display("FAIL accept: got data=%h cond=%b%b in_ready=%b r=%b, want data=%h cond=%b in_ready=0 r=%b",
                  data, cond2, cond1, in_ready, r, word, mask, exp_r);
      end
      if (hold) begin
         in_data = nword;
         in_cond = nmask;
      end else begin
         in_valid = 1'b0;
         in_data  = W'($urandom);
         in_cond  = 2'($urandom);
      end
      @(negedge clk);
      exp_r = ~exp_r;
      n_checks++;
      if ({r, busy, in_ready} !== {exp_r, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL req_toggle: got r=%b busy=%b in_ready=%b, want r=%b busy=1 in_ready=0",
                  r, busy, in_ready, exp_r);
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         n_checks++;
         if ({data, cond2, cond1, busy, in_ready} !== {word, mask, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_hold: got data=%h cond=%b%b busy=%b in_ready=%b, want data=%h cond=%b busy=1 in_ready=0",
                     data, cond2, cond1, busy, in_ready, word, mask);
         end
      end
      a = exp_r;
      k = 0;
      while (in_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k != SYNC + 1) begin
         n_fail++;
         $display("FAIL ack_latency: got %0d cycles from ack to in_ready, want %0d", k, SYNC + 1);
      end
      n_checks++;
      if ({err, r, busy} !== {exp_err, exp_r, 1'b0}) begin
         n_fail++;
         $display("FAIL done_state: got err=%b r=%b busy=%b, want err=%b r=%b busy=0",
                  err, r, busy, exp_err, exp_r);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({r, data, cond1, cond2, busy, err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values: got r=%b data=%h c1=%b c2=%b busy=%b err=%b in_ready=%b, want all 0 and in_ready=1",
                  r, data, cond1, cond2, busy, err, in_ready);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, busy, err} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_release: got in_ready=%b busy=%b err=%b, want 1 0 0", in_ready, busy, err);
      end
   endtask

   task automatic test_basic();
      do_transfer(8'hA5, 2'b01, 5, 1'b0, 8'h00, 2'b00);
   endtask

   task automatic test_back_to_back();
      do_transfer(8'h5A, 2'b11, 4, 1'b1, 8'hC3, 2'b10);
      do_transfer(8'hC3, 2'b10, 3, 1'b0, 8'h00, 2'b00);
   endtask

   task automatic test_mask_zero();
      do_transfer(8'h77, 2'b00, 2, 1'b0, 8'h00, 2'b00);
   endtask

   task automatic test_random();
      logic [W-1:0] w;
      logic [1:0]   m;
      logic [W-1:0] nw;
      logic [1:0]   nm;
      bit           h;
      w = W'($urandom);
      m = 2'($urandom);
      for (int i = 0; i < 10; i++) begin
         nw = W'($urandom);
         nm = 2'($urandom);
         h  = (i < 9) ? 1'($urandom) : 1'b0;
         do_transfer(w, m, int'($urandom_range(1, 7)), h, nw, nm);
         w = nw;
         m = nm;
      end
   endtask

   task automatic test_timeout();
      logic want;
      int   k;
      in_valid = 1'b1;
      in_data  = 8'h96;
      in_cond  = 2'b10;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      exp_r = ~exp_r;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
`ifdef FORK_COND2_SRC_TIMEOUT_EN
         want = exp_err | (i >= TO - 1);
`else
         want = exp_err;
`endif
         n_checks++;
         if ({err, busy} !== {want, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_err: cycle %0d in WAIT got err=%b busy=%b, want err=%b busy=1", i, err, busy, want);
         end
      end
`ifdef FORK_COND2_SRC_TIMEOUT_EN
      exp_err = 1'b1;
`endif
      a = exp_r;
      k = 0;
      while (in_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k != SYNC + 1) begin
         n_fail++;
         $display("FAIL late_ack: got %0d cycles from ack to in_ready, want %0d", k, SYNC + 1);
      end
   endtask

   task automatic test_spurious();
      a = ~exp_r;
      repeat (4) @(negedge clk);
      a = exp_r;
      exp_err = 1'b1;
      repeat (SYNC + 1) @(negedge clk);
      n_checks++;
      if ({err, in_ready, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL spurious: got err=%b in_ready=%b busy=%b, want err=1 in_ready=1 busy=0", err, in_ready, busy);
      end
      do_transfer(8'h3E, 2'b01, 3, 1'b0, 8'h00, 2'b00);
   endtask

   task automatic test_reset_mid_wait();
      if (exp_r) begin
         do_transfer(8'h11, 2'b10, 2, 1'b0, 8'h00, 2'b00);
      end
      in_valid = 1'b1;
      in_data  = 8'h3C;
      in_cond  = 2'b11;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rstn = 1'b0;
      a    = 1'b0;
      #1;
      n_checks++;
      if ({r, cond1, cond2, data, busy, err} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got r=%b c1=%b c2=%b data=%h busy=%b err=%b, want all 0",
                  r, cond1, cond2, data, busy, err);
      end
      exp_r   = 1'b0;
      exp_err = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, busy, err} !== 3'b100) begin
         n_fail++;
         $display("FAIL post_reset: got in_ready=%b busy=%b err=%b, want 1 0 0", in_ready, busy, err);
      end
      do_transfer(8'hE1, 2'b11, 2, 1'b0, 8'h00, 2'b00);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_mask_zero();
      test_random();
      test_timeout();
      test_spurious();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
